// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states, default ID word
// and the byte-strobe merge helpers used by the register bank.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  localparam logic [APB_DATA_W-1:0] APB_ID_DEFAULT = 32'hA5B0_0001;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  function automatic logic [APB_DATA_W-1:0] strb_mask(input logic [APB_STRB_W-1:0] strb);
    logic [APB_DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < APB_STRB_W; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  function automatic logic [APB_DATA_W-1:0] strb_merge(input logic [APB_DATA_W-1:0] old_data,
                                                       input logic [APB_DATA_W-1:0] wdata,
                                                       input logic [APB_DATA_W-1:0] mask);
    return (old_data & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/apb_regbank.sv
// Word register storage with a synchronous byte-strobed write port and a
// combinational read port; index 0 always reads back the constant ID.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS = 8,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = APB_ID_DEFAULT,
  parameter int                    IDX_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]      ridx,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [NUM_REGS];

  // Slot 0 backs the read-only ID and is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (widx != '0)) begin
      mem[widx] <= strb_merge(mem[widx], wdata, strb_mask(wstrb));
    end
  end

  assign rdata = (ridx == '0) ? ID_VALUE : mem[ridx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a strobed register bank, programmable wait states and
// PSLVERR for misaligned, out-of-range or read-only accesses.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 1,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = APB_ID_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  apb_state_e            state;
  logic [3:0]            cnt;
  logic                  err_q;
  logic                  write_q;
  logic [IDX_W-1:0]      idx_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_STRB_W-1:0] strb_q;
  logic [APB_DATA_W-1:0] rdata_q;

  logic [29:0]           word_addr;
  logic [IDX_W-1:0]      idx_in;
  logic                  setup_err;
  logic                  ready;
  logic                  we;
  logic [APB_DATA_W-1:0] bank_rdata;

  assign word_addr = PADDR[31:2];
  assign idx_in    = PADDR[IDX_W+1:2];
  assign setup_err = (PADDR[1:0] != 2'b00) || (word_addr >= 30'(NUM_REGS)) ||
                     (PWRITE && (word_addr == 30'd0));

  assign ready = (state == ACCESS) && (cnt == 4'd0);
  assign we    = ready && PSEL && PENABLE && write_q && !err_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // PSEL with PENABLE already high is a protocol violation and is ignored.
          if (PSEL && !PENABLE) begin
            err_q   <= setup_err;
            write_q <= PWRITE;
            idx_q   <= idx_in;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            rdata_q <= (setup_err || PWRITE) ? '0 : bank_rdata;
            cnt     <= 4'(WAIT_STATES);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .ridx  (idx_in),
    .rdata (bank_rdata)
  );

  assign PREADY  = ready;
  assign PSLVERR = ready && err_q;
  assign PRDATA  = ready ? rdata_q : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench driving three completers (0, 3 and 2 wait states) over one
// shared APB bus, with hand-computed expectations for every transfer.
module tb_apb_slave_regfile;

  logic        PCLK;
  logic        PRESET;
  logic        psel;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  int          target;

  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int checks;
  int fails;

  logic [31:0] rd;
  logic        er;
  int          cyc;

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel && (target == 0)), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(3)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel && (target == 1)), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(2)) dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel && (target == 2)), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transfer driven and sampled on falling edges; optional scramble
  // changes PADDR/PWDATA during ACCESS to show they are not resampled.
  task automatic applyStimulus(input int dut, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic scramble, output logic [31:0] rdata,
                               output logic err, output int cycles);
    target  = dut;
    psel    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    PSTRB   = strb;
    @(negedge PCLK);
    PENABLE = 1'b1;
    if (scramble) begin
      PADDR  = addr + 32'd4;
      PWDATA = ~wdata;
    end
    cycles = 1;
    while (!pready[dut] && cycles < 40) begin
      @(negedge PCLK);
      cycles++;
    end
    if (!pready[dut]) begin
      checkOutput("pready_timeout", 32'(pready[dut]), 32'd1);
    end
    rdata = prdata[dut];
    err   = pslverr[dut];
    @(negedge PCLK);
    psel    = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    target  = 0;
    psel    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    PSTRB   = '0;
    PRESET  = 1'b1;
    repeat (2) @(negedge PCLK);
    checkOutput("rst_pready", {pready[0], pready[1], pready[2]}, 32'd0);
    checkOutput("rst_pslverr", {pslverr[0], pslverr[1], pslverr[2]}, 32'd0);
    checkOutput("rst_prdata", prdata[0] | prdata[1] | prdata[2], 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Zero wait states: write then read back
    applyStimulus(0, 1'b1, 32'h04, 32'h1234_5678, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("ws0_wr_cycles", cyc, 1);
    checkOutput("ws0_wr_err", 32'(er), 0);
    checkOutput("ws0_pready_one_cycle", 32'(pready[0]), 0);
    applyStimulus(0, 1'b0, 32'h04, 32'h0, 4'b0000, 1'b0, rd, er, cyc);
    checkOutput("ws0_rd_data", rd, 32'h1234_5678);
    checkOutput("ws0_rd_err", 32'(er), 0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("ws0_rd_reset_val", rd, 32'h0);

    // Three wait states with partial strobes
    applyStimulus(1, 1'b1, 32'h08, 32'h1111_1111, 4'b1111, 1'b0, rd, er, cyc);
    applyStimulus(1, 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, er, cyc);
    checkOutput("ws3_wr_cycles", cyc, 4);
    checkOutput("ws3_wr_err", 32'(er), 0);
    checkOutput("ws3_pready_one_cycle", 32'(pready[1]), 0);
    applyStimulus(1, 1'b0, 32'h08, 32'h0, 4'b0000, 1'b0, rd, er, cyc);
    checkOutput("ws3_rd_strobed", rd, 32'h11BB_11DD);
    checkOutput("ws3_rd_cycles", cyc, 4);
    applyStimulus(1, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'b0000, 1'b0, rd, er, cyc);
    checkOutput("ws3_strb0_err", 32'(er), 0);
    applyStimulus(1, 1'b0, 32'h08, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("ws3_strb0_unchanged", rd, 32'h11BB_11DD);
    applyStimulus(1, 1'b1, 32'h00, 32'hDEAD_BEEF, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("ws3_err_cycles", cyc, 4);
    checkOutput("ws3_err_flag", 32'(er), 1);

    // Inputs changed during ACCESS must not affect the latched transfer
    applyStimulus(1, 1'b1, 32'h14, 32'h0000_CAFE, 4'b1111, 1'b1, rd, er, cyc);
    applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("scramble_target", rd, 32'h0000_CAFE);
    applyStimulus(1, 1'b0, 32'h18, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("scramble_neighbour", rd, 32'h0);

    // Error accesses on the zero-wait completer
    applyStimulus(0, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("err_wr_id_flag", 32'(er), 1);
    checkOutput("err_wr_id_data", rd, 32'h0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("err_rd_range_flag", 32'(er), 1);
    checkOutput("err_rd_range_data", rd, 32'h0);
    applyStimulus(0, 1'b1, 32'h20, 32'h5555_5555, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("err_wr_range_flag", 32'(er), 1);
    applyStimulus(0, 1'b0, 32'h06, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("err_rd_misalign_flag", 32'(er), 1);
    checkOutput("err_rd_misalign_data", rd, 32'h0);
    applyStimulus(0, 1'b1, 32'h06, 32'h7777_7777, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("err_wr_misalign_flag", 32'(er), 1);
    applyStimulus(0, 1'b0, 32'h04, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("err_reg1_intact", rd, 32'h1234_5678);
    applyStimulus(0, 1'b0, 32'h00, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("id_value", rd, 32'hA5B0_0001);
    checkOutput("id_err", 32'(er), 0);

    // Abort during the second access cycle of a two-wait-state write
    applyStimulus(2, 1'b1, 32'h08, 32'h0000_00AA, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("ws2_wr_cycles", cyc, 3);
    target  = 2;
    psel    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h08;
    PWDATA  = 32'hFFFF_0000;
    PSTRB   = 4'b1111;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    psel    = 1'b0;
    PENABLE = 1'b0;
    @(negedge PCLK);
    checkOutput("abort_pready", 32'(pready[2]), 0);
    applyStimulus(2, 1'b0, 32'h08, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("abort_no_write", rd, 32'h0000_00AA);
    checkOutput("abort_next_cycles", cyc, 3);

    // PSEL and PENABLE together from IDLE is ignored
    target  = 2;
    psel    = 1'b1;
    PENABLE = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 32'h08;
    PWDATA  = 32'h0000_1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      checkOutput("violation_pready", 32'(pready[2]), 0);
    end
    psel    = 1'b0;
    PENABLE = 1'b0;
    @(negedge PCLK);
    applyStimulus(2, 1'b0, 32'h08, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("violation_no_write", rd, 32'h0000_00AA);
    checkOutput("violation_cycles", cyc, 3);

    // Reset asserted in the access cycle of a write to register 3
    applyStimulus(0, 1'b1, 32'h0C, 32'hDEAD_BEEF, 4'b1111, 1'b0, rd, er, cyc);
    applyStimulus(0, 1'b0, 32'h0C, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("pre_reset_reg3", rd, 32'hDEAD_BEEF);
    target  = 0;
    psel    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h0C;
    PWDATA  = 32'h5555_5555;
    PSTRB   = 4'b1111;
    @(negedge PCLK);
    PENABLE = 1'b1;
    checkOutput("midrst_pready_before", 32'(pready[0]), 1);
    PRESET  = 1'b1;
    @(negedge PCLK);
    checkOutput("midrst_pready", 32'(pready[0]), 0);
    checkOutput("midrst_pslverr", 32'(pslverr[0]), 0);
    checkOutput("midrst_prdata", prdata[0], 32'h0);
    PRESET  = 1'b0;
    psel    = 1'b0;
    PENABLE = 1'b0;
    @(negedge PCLK);
    applyStimulus(0, 1'b0, 32'h0C, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("midrst_reg3_cleared", rd, 32'h0);
    checkOutput("midrst_reg3_err", 32'(er), 0);
    applyStimulus(0, 1'b1, 32'h1C, 32'h0BAD_F00D, 4'b0011, 1'b0, rd, er, cyc);
    applyStimulus(0, 1'b0, 32'h1C, 32'h0, 4'b1111, 1'b0, rd, er, cyc);
    checkOutput("post_rst_transfer", rd, 32'h0000_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
